// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: issue-side bus of the bit-serial add/subtract sequencer
// Ports: start/sub/op_a/op_b/c_in from the issuer (master);
//        busy/done/result/c_out/overflow from the sequencer (slave).
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    modport master (output start, sub, op_a, op_b, c_in, input busy, done, result, c_out, overflow);
    modport slave  (input start, sub, op_a, op_b, c_in, output busy, done, result, c_out, overflow);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract, one full_adder driven LSB-first over WIDTH cycles
// Ports: clk (rising edge), rst_n (async active-low), bus (serial_adder_ctrl_if.slave):
//        start/sub/op_a/op_b/c_in sampled in IDLE; busy in RUN+DONE; done one-cycle pulse;
//        result/c_out/overflow valid from done, held until the next accepted start.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(parameter int WIDTH = 8) (
    input logic                clk,
    input logic                rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             busy;
    logic             done;
    logic             c_out;
    logic             overflow;
    logic             fa_sum;
    logic             fa_c;
    full_adder fa (.a(a_sh[0]), .b(b_sh[0]), .c_in(carry), .sum(fa_sum), .c_out(fa_c));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            result   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    // subtraction is A + ~B + 1, the +1 riding in on the initial carry
                    state  <= RUN;
                    busy   <= 1'b1;
                    a_sh   <= bus.op_a;
                    b_sh   <= bus.sub ? ~bus.op_b : bus.op_b;
                    carry  <= bus.sub | bus.c_in;
                    cnt    <= '0;
                    result <= '0;
                end
                RUN: begin
                    result <= {fa_sum, result[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here
                        c_out    <= fa_c;
                        overflow <= carry ^ fa_c;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.result   = result;
    assign bus.c_out    = c_out;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of serial_adder_ctrl against a behavioural model
module tb_serial_adder_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int passed = 0;
    serial_adder_ctrl_if #(W) bus ();
    serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: an op occupies the sequencer for W+1 cycles after its accepting edge,
    // done in the last of them; outputs come from plain integer arithmetic.
    int   left = 0;
    int   p_res = 0, e_res = 0;
    logic p_c = 0, p_v = 0, e_c = 0, e_v = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left = 0; e_res = 0; e_c = 0; e_v = 0;
        end else if (left > 0) begin
            left--;
            if (left == 1) begin e_res = p_res; e_c = p_c; e_v = p_v; end
        end else if (bus.start) begin
            int a, b, sa, sb, s, ss;
            a = int'(bus.op_a);
            b = int'(bus.op_b);
            sa = int'($signed(bus.op_a));
            sb = int'($signed(bus.op_b));
            if (bus.sub) begin
                s = a - b; ss = sa - sb; p_c = (a >= b);
            end else begin
                s = a + b + int'(bus.c_in); ss = sa + sb + int'(bus.c_in); p_c = (s > 255);
            end
            p_res = s & 255;
            p_v = (ss < -128) || (ss > 127);
            left = W + 1;
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("busy", bus.busy, left > 0);
        chk("done", bus.done, left == 1);
        if (left <= 1) begin
            chk("result", bus.result, e_res);
            chk("c_out", bus.c_out, e_c);
            chk("overflow", bus.overflow, e_v);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin @(posedge clk); #1; n++; end
        if (bus.busy) chk("idle_wait", bus.busy, 0);
    endtask

    task automatic issue(input logic s, input logic [7:0] a, input logic [7:0] b, input logic ci);
        wait_idle();
        @(posedge clk); #1;
        bus.start = 1; bus.sub = s; bus.op_a = a; bus.op_b = b; bus.c_in = ci;
        @(posedge clk); #1;
        bus.start = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
        if (!bus.done) chk("done_wait", bus.done, 1);
    endtask

    task automatic op(input string nm, input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [7:0] er, input logic ec, input logic ev);
        int n;
        issue(s, a, b, ci);
        wait_done(n);
        chk({nm, "_latency"}, n, W);
        chk({nm, "_res"}, bus.result, er);
        chk({nm, "_c"}, bus.c_out, ec);
        chk({nm, "_v"}, bus.overflow, ev);
        @(posedge clk); #1;
        chk({nm, "_done_len"}, bus.done, 0);
    endtask

    initial begin
        int n, pulses, first, second;
        logic [7:0] held;
        bus.start = 0; bus.sub = 0; bus.op_a = 0; bus.op_b = 0; bus.c_in = 0;
        #1 rst_n = 0;
        #20;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_res", bus.result, 0);
        chk("rst_c", bus.c_out, 0);
        chk("rst_v", bus.overflow, 0);
        @(posedge clk); #3 rst_n = 1;

        op("add0f01", 0, 8'h0F, 8'h01, 0, 8'h10, 0, 0);
        op("addff01", 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);
        op("add7f01", 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1);
        op("addcin",  0, 8'h00, 8'h00, 1, 8'h01, 0, 0);
        op("sub0507", 1, 8'h05, 8'h07, 0, 8'hFE, 0, 0);
        op("sub0705", 1, 8'h07, 8'h05, 1, 8'h02, 1, 0);
        op("sub8001", 1, 8'h80, 8'h01, 0, 8'h7F, 1, 1);

        // start and operand changes during RUN are ignored
        issue(0, 8'h10, 8'h20, 0);
        repeat (2) @(posedge clk);
        #1 bus.start = 1; bus.sub = 1; bus.op_a = 8'h55; bus.op_b = 8'h55;
        @(posedge clk); #1 bus.start = 0;
        pulses = 0; held = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin pulses++; held = bus.result; end
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_res", held, 8'h30);

        // async reset in the middle of RUN, after an op that left c_out=1
        op("pre_rst", 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);
        issue(0, 8'h7F, 8'h7F, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_res", bus.result, 0);
        chk("mid_rst_c", bus.c_out, 0);
        chk("mid_rst_v", bus.overflow, 0);
        @(posedge clk); #3 rst_n = 1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        chk("mid_rst_nodone", pulses, 0);
        op("post_rst", 0, 8'h22, 8'h11, 0, 8'h33, 0, 0);

        // start held high: one op every W+2 cycles
        wait_idle();
        @(posedge clk); #1;
        bus.start = 1; bus.sub = 0; bus.op_a = 8'h12; bus.op_b = 8'h34; bus.c_in = 0;
        pulses = 0; first = 0; second = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                pulses++;
                if (pulses == 1) first = i;
                if (pulses == 2) second = i;
                chk("held_res", bus.result, 8'h46);
            end
        end
        bus.start = 0;
        chk("held_pulses", pulses, 3);
        chk("held_period", second - first, W + 2);

        for (int k = 0; k < 1000; k++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            wait_done(n);
        end
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
